// File: rtl/tri_fu_tblmul_bthrec_pkg.sv
// Shared constants and types for the radix-4 Booth digit reassembler.
// Holds the digit-code layout {s_neg, s_x, s_x2} and the FSM state type.
package tri_fu_tblmul_bthrec_pkg;

   localparam int unsigned DIGITS_DEF = 8;

   // Bit positions inside the 3-bit digit code {s_neg, s_x, s_x2}
   localparam int unsigned CODE_NEG = 2;
   localparam int unsigned CODE_X   = 1;
   localparam int unsigned CODE_X2  = 0;
   localparam logic [2:0]  CODE_ILL = 3'b011;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

endpackage

// File: rtl/tri_fu_tblmul_bthrec_if.sv
// Digit-in / operand-out handshake bundle for the Booth reassembler.
interface tri_fu_tblmul_bthrec_if
   import tri_fu_tblmul_bthrec_pkg::*;
#(
   parameter int unsigned DIGITS = DIGITS_DEF
);
   logic                in_valid;
   logic                in_ready;
   logic                s_neg;
   logic                s_x;
   logic                s_x2;
   logic                out_valid;
   logic                out_ready;
   logic [0:2*DIGITS-1] out_value;
   logic                out_err;

   modport master (
      output in_valid, s_neg, s_x, s_x2, out_ready,
      input  in_ready, out_valid, out_value, out_err
   );

   modport slave (
      input  in_valid, s_neg, s_x, s_x2, out_ready,
      output in_ready, out_valid, out_value, out_err
   );
endinterface

// File: rtl/tri_fu_tblmul_bthrec_bthval.sv
// Combinational Booth digit decode: {s_neg, s_x, s_x2} -> signed value in -2..2
// plus an illegal-code flag (s_x and s_x2 both set decodes to 0).
module tri_fu_tblmul_bthval
   import tri_fu_tblmul_bthrec_pkg::*;
(
   input  logic [2:0]        code_i,
   output logic signed [2:0] val_o,
   output logic              illegal_o
);
   logic [2:0] mag;

   always_comb begin
      illegal_o = ((code_i & CODE_ILL) == CODE_ILL);
      mag       = '0;
      if (!illegal_o) begin
         if (code_i[CODE_X2])
            mag = 3'd2;
         else if (code_i[CODE_X])
            mag = 3'd1;
      end
      val_o = code_i[CODE_NEG] ? -mag : mag;
   end
endmodule

// File: rtl/tri_fu_tblmul_bthrec.sv
// Reassembles a W-bit two's-complement operand from DIGITS radix-4 Booth
// digits (LS digit first) and presents it until the consumer takes it.
module tri_fu_tblmul_bthrec
   import tri_fu_tblmul_bthrec_pkg::*;
#(
   parameter int unsigned DIGITS = DIGITS_DEF
)
(
   input logic                   clk,
   input logic                   rst,
   tri_fu_tblmul_bthrec_if.slave bus
);
   localparam int unsigned W  = 2 * DIGITS;
   localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_e          state_q, state_d;
   logic [W-1:0]    acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            err_q, err_d;

   logic signed [2:0]   dig_val;
   logic                dig_ill;
   logic signed [W-1:0] dig_ext;
   logic [W-1:0]        dig_sh;
   logic                accept;
   logic                last;

   tri_fu_tblmul_bthval u_val (
      .code_i    ({bus.s_neg, bus.s_x, bus.s_x2}),
      .val_o     (dig_val),
      .illegal_o (dig_ill)
   );

   // Sign-extend the digit, then weight it by 4^k; wraps modulo 2^W.
   assign dig_ext = W'(dig_val);
   assign dig_sh  = dig_ext << {cnt_q, 1'b0};
   assign last    = (cnt_q == CW'(DIGITS - 1));
   assign accept  = bus.in_valid && (state_q != ST_HOLD);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE, ST_ACCUM: begin
            if (accept) begin
               acc_d = acc_q + dig_sh;
               err_d = err_q | dig_ill;
               if (last) begin
                  state_d = ST_HOLD;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_ACCUM;
                  cnt_d   = cnt_q + 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (bus.out_ready) begin
               state_d = ST_IDLE;
               acc_d   = '0;
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are forced to their idle values while rst is high.
   assign bus.in_ready  = rst || (state_q != ST_HOLD);
   assign bus.out_valid = !rst && (state_q == ST_HOLD);
   assign bus.out_value = rst ? '0 : acc_q;
   assign bus.out_err   = !rst && err_q;
endmodule

// File: tb/tb_tri_fu_tblmul_bthrec.sv
// Directed and randomized bench for the Booth digit reassembler, DIGITS = 8.
module tb_tri_fu_tblmul_bthrec;
   localparam int unsigned ND = 8;

   typedef logic [2:0] codes_t [ND];

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   tri_fu_tblmul_bthrec_if #(.DIGITS(ND)) bus ();

   tri_fu_tblmul_bthrec #(.DIGITS(ND)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Digit value from the code rules: illegal -> 0, else +/- magnitude.
   function automatic int dval(input logic [2:0] c);
      int mag;
      if (c[1] && c[0]) return 0;
      mag = c[1] ? 1 : (c[0] ? 2 : 0);
      return c[2] ? -mag : mag;
   endfunction

   function automatic logic [15:0] model_sum(input codes_t c);
      longint s;
      logic [63:0] t;
      s = 0;
      for (int k = 0; k < ND; k++) s += longint'(dval(c[k])) * (longint'(1) << (2 * k));
      t = 64'(s);
      return t[15:0];
   endfunction

   function automatic logic model_err(input codes_t c);
      for (int k = 0; k < ND; k++) if (c[k][1] && c[k][0]) return 1'b1;
      return 1'b0;
   endfunction

   // Standard radix-4 Booth encode of an operand, bits 2k+1, 2k, 2k-1.
   function automatic codes_t booth_encode(input logic [15:0] op);
      codes_t c;
      logic [16:0] e;
      int d;
      e = {op, 1'b0};
      for (int k = 0; k < ND; k++) begin
         d = -2 * int'(e[2*k+2]) + int'(e[2*k+1]) + int'(e[2*k]);
         c[k][2] = (d < 0) || (d == 0 && $urandom_range(1) == 1);
         c[k][1] = (d == 1) || (d == -1);
         c[k][0] = (d == 2) || (d == -2);
      end
      return c;
   endfunction

   task automatic send_op(input codes_t c, input int unsigned gap_pct, input string tag);
      int gaps;
      for (int k = 0; k < ND; k++) begin
         gaps = 0;
         while (gaps < 4 && $urandom_range(99) < gap_pct) begin
            bus.in_valid = 1'b0;
            {bus.s_neg, bus.s_x, bus.s_x2} = 3'($urandom);
            step();
            gaps++;
         end
         check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
         bus.in_valid = 1'b1;
         {bus.s_neg, bus.s_x, bus.s_x2} = c[k];
         step();
         if (k < ND - 1) check({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
      end
      bus.in_valid = 1'b0;
      check({tag, "_latency"}, 32'(bus.out_valid), 32'd1);
   endtask

   task automatic finish_op(input logic [15:0] exp_v, input logic exp_e, input string tag);
      check({tag, "_value"}, 32'(bus.out_value), 32'(exp_v));
      check({tag, "_err"}, 32'(bus.out_err), 32'(exp_e));
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check({tag, "_released"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      codes_t c;
      logic [15:0] op, held;
      bus.in_valid  = 1'b0;
      bus.s_neg     = 1'b0;
      bus.s_x       = 1'b0;
      bus.s_x2      = 1'b0;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_value", 32'(bus.out_value), 32'd0);
      check("rst_out_err", 32'(bus.out_err), 32'd0);
      step();
      step();
      rst = 1'b0;

      // 0x0001
      for (int k = 0; k < ND; k++) c[k] = 3'b000;
      c[0] = 3'b010;
      send_op(c, 0, "op0001");
      finish_op(16'h0001, 1'b0, "op0001");

      // 0xFFFF using negative-zero upper digits
      for (int k = 0; k < ND; k++) c[k] = 3'b100;
      c[0] = 3'b110;
      send_op(c, 0, "opFFFF");
      finish_op(16'hFFFF, 1'b0, "opFFFF");

      // 0x8000: top digit -2
      for (int k = 0; k < ND; k++) c[k] = 3'b000;
      c[7] = 3'b101;
      send_op(c, 0, "op8000");
      finish_op(16'h8000, 1'b0, "op8000");

      // Illegal digit 3, then a clean operand clears the error
      for (int k = 0; k < ND; k++) c[k] = 3'b000;
      c[0] = 3'b010;
      c[3] = 3'b011;
      send_op(c, 0, "ill");
      finish_op(16'h0001, 1'b1, "ill");
      c[3] = 3'b000;
      send_op(c, 0, "clean");
      finish_op(16'h0001, 1'b0, "clean");

      // HOLD stalls with in_valid asserted; no digit may be consumed
      c = booth_encode(16'h1234);
      send_op(c, 0, "hold");
      held = 16'(bus.out_value);
      check("hold_value", 32'(held), 32'h1234);
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         {bus.s_neg, bus.s_x, bus.s_x2} = 3'b010;
         step();
         check("hold_stable", 32'(bus.out_value), 32'(held));
         check("hold_in_ready", 32'(bus.in_ready), 32'd0);
         check("hold_valid", 32'(bus.out_valid), 32'd1);
      end
      bus.in_valid = 1'b0;
      finish_op(16'h1234, 1'b0, "hold_rel");
      for (int k = 0; k < ND; k++) c[k] = 3'b000;
      c[0] = 3'b010;
      send_op(c, 0, "post_hold");
      finish_op(16'h0001, 1'b0, "post_hold");

      // Reset mid-operand after 4 digits
      c = booth_encode(16'hBEEF);
      for (int k = 0; k < 4; k++) begin
         bus.in_valid = 1'b1;
         {bus.s_neg, bus.s_x, bus.s_x2} = c[k];
         step();
      end
      bus.in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 0; k < ND; k++) c[k] = 3'b000;
      c[0] = 3'b010;
      send_op(c, 0, "after_rst");
      finish_op(16'h0001, 1'b0, "after_rst");

      // Reset while in HOLD: outputs forced immediately, state cleared on the edge
      c = booth_encode(16'h7F3C);
      send_op(c, 0, "rst_hold");
      rst = 1'b1;
      #1;
      check("rst_hold_valid", 32'(bus.out_valid), 32'd0);
      check("rst_hold_value", 32'(bus.out_value), 32'd0);
      check("rst_hold_ready", 32'(bus.in_ready), 32'd1);
      step();
      rst = 1'b0;
      #1;
      check("rst_hold_idle", 32'(bus.out_valid), 32'd0);

      // Random operands with random gaps, checked against the operand itself
      for (int n = 0; n < 20; n++) begin
         op = 16'($urandom);
         c = booth_encode(op);
         send_op(c, (n % 2 == 0) ? 0 : 40, "rnd");
         finish_op(op, 1'b0, "rnd");
      end

      // Random operands with one illegal digit, checked against the digit-sum model
      for (int n = 0; n < 8; n++) begin
         c = booth_encode(16'($urandom));
         c[$urandom_range(ND - 1)] = ($urandom_range(1) == 1) ? 3'b111 : 3'b011;
         send_op(c, 30, "rnd_ill");
         finish_op(model_sum(c), model_err(c), "rnd_ill");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
